column_chain_reader: RTL and testbench

Consumer end of the column switch-cell chain. It sits in the global readout under each pair of half-column chains (right, columns 0–7; left, columns 8–15). It watches the `dnUnreadHitRight`/`dnUnreadHitLeft` flags and captures `dnDataRight`/`dnDataLeft`. It pulses the matching `dnRead` strobe and buffers the captured 46-bit words in a small FIFO for the downstream frame builder. It also registers and fans out the broadcast word onto `dnBCSTRight` and `dnBCSTLeft`.

---
 rtl/column_chain_reader_pkg.sv | 31 +++
 rtl/column_chain_reader_fifo.sv | 64 ++++++
 rtl/column_chain_reader.sv | 147 ++++++++++++++
 tb/tb_column_chain_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/column_chain_reader_pkg.sv
// Shared readout definitions for the column chain consumer: default widths,
// side encoding, FSM states and the round-robin side picker.
package readoutDefs;

  localparam int DEFAULT_DATAWIDTH = 46;
  localparam int DEFAULT_BCSTWIDTH = 27;

  localparam logic SIDE_RIGHT = 1'b0;
  localparam logic SIDE_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } readState_e;

  // On a tie the side not served last wins; otherwise the only requesting side.
  function automatic logic pickSide(input logic hitRight, input logic hitLeft,
                                    input logic lastSide);
    logic side;
    if (hitRight && hitLeft) begin
      side = ~lastSide;
    end else if (hitLeft) begin
      side = SIDE_LEFT;
    end else begin
      side = SIDE_RIGHT;
    end
    return side;
  endfunction

endpackage

// File: rtl/column_chain_reader_fifo.sv
// Small synchronous FIFO holding captured {side, data} hit words.
// The head reads as zero while empty so the output port is clean after reset.
module hit_word_fifo #(
  parameter int WIDTH = 47,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   EMPTY_COUNT = {(AW+1){1'b0}};
  localparam logic [AW:0]   COUNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [AW:0]      count_r;
  logic             doPush_s;
  logic             doPop_s;

  assign doPop_s  = pop && (count_r != EMPTY_COUNT);
  assign doPush_s = push && ((count_r != FULL_COUNT) || doPop_s);
  assign empty    = (count_r == EMPTY_COUNT);
  assign count    = count_r;
  assign popData  = empty ? {WIDTH{1'b0}} : mem_r[rdPtr_r];

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
      count_r <= EMPTY_COUNT;
    end else begin
      if (doPush_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    if (doPush_s) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

endmodule

// File: rtl/column_chain_reader.sv
// Consumer end of the right/left column switch-cell chains: arbitrates unread
// hits, strobes the chain, buffers words, counts them and fans out broadcast.
module column_chain_reader
  import readoutDefs::*;
#(
  parameter int BCSTWIDTH = DEFAULT_BCSTWIDTH,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int SETTLE    = 2,
  parameter int DEPTH     = 4,
  parameter int CNTWIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readEnable,
  input  logic [BCSTWIDTH-1:0] bcstIn,
  input  logic                 clearCount,
  input  logic [DATAWIDTH-1:0] dnDataRight,
  input  logic                 dnUnreadHitRight,
  output logic                 dnReadRight,
  output logic [BCSTWIDTH-1:0] dnBCSTRight,
  input  logic [DATAWIDTH-1:0] dnDataLeft,
  input  logic                 dnUnreadHitLeft,
  output logic                 dnReadLeft,
  output logic [BCSTWIDTH-1:0] dnBCSTLeft,
  output logic [DATAWIDTH:0]   outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [CNTWIDTH-1:0]  wordCountRight,
  output logic [CNTWIDTH-1:0]  wordCountLeft,
  output logic                 busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]       FIFO_FULL   = CW'(DEPTH);
  localparam logic [3:0]          SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [CNTWIDTH-1:0] CNT_MAX     = {CNTWIDTH{1'b1}};
  localparam logic [CNTWIDTH-1:0] CNT_ONE     = CNTWIDTH'(1'b1);

  readState_e       state_r;
  logic             lastSide_r;
  logic [3:0]       settleCnt_r;
  logic             startRead_s;
  logic             selSide_s;
  logic [DATAWIDTH:0] pushData_s;
  logic [CW-1:0]    fifoCount_s;
  logic             fifoEmpty_s;

  assign selSide_s   = pickSide(dnUnreadHitRight, dnUnreadHitLeft, lastSide_r);
  assign startRead_s = (state_r == IDLE) && readEnable &&
                       (dnUnreadHitRight || dnUnreadHitLeft) &&
                       (fifoCount_s < FIFO_FULL);
  assign pushData_s  = {selSide_s, (selSide_s == SIDE_LEFT) ? dnDataLeft : dnDataRight};
  assign outValid    = ~fifoEmpty_s;

  hit_word_fifo #(
    .WIDTH (DATAWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (startRead_s),
    .pushData (pushData_s),
    .pop      (outReady),
    .popData  (outData),
    .empty    (fifoEmpty_s),
    .count    (fifoCount_s)
  );

  // Read sequencer: capture, one-cycle strobe, then wait for the chain to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      lastSide_r  <= SIDE_LEFT;
      settleCnt_r <= 4'd0;
      dnReadRight <= 1'b0;
      dnReadLeft  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (startRead_s) begin
            state_r     <= READ;
            lastSide_r  <= selSide_s;
            dnReadRight <= (selSide_s == SIDE_RIGHT);
            dnReadLeft  <= (selSide_s == SIDE_LEFT);
            busy        <= 1'b1;
          end
        end
        READ: begin
          dnReadRight <= 1'b0;
          dnReadLeft  <= 1'b0;
          settleCnt_r <= SETTLE_LOAD;
          if (SETTLE == 0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (settleCnt_r == 4'd0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            settleCnt_r <= settleCnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          dnReadRight <= 1'b0;
          dnReadLeft  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Saturating per-side word counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordCountRight <= {CNTWIDTH{1'b0}};
      wordCountLeft  <= {CNTWIDTH{1'b0}};
    end else if (clearCount) begin
      wordCountRight <= {CNTWIDTH{1'b0}};
      wordCountLeft  <= {CNTWIDTH{1'b0}};
    end else begin
      if (startRead_s && (selSide_s == SIDE_RIGHT) && (wordCountRight != CNT_MAX)) begin
        wordCountRight <= wordCountRight + CNT_ONE;
      end
      if (startRead_s && (selSide_s == SIDE_LEFT) && (wordCountLeft != CNT_MAX)) begin
        wordCountLeft <= wordCountLeft + CNT_ONE;
      end
    end
  end

  // Broadcast fan-out register, identical on both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dnBCSTRight <= {BCSTWIDTH{1'b0}};
      dnBCSTLeft  <= {BCSTWIDTH{1'b0}};
    end else begin
      dnBCSTRight <= bcstIn;
      dnBCSTLeft  <= bcstIn;
    end
  end

endmodule

// File: tb/tb_column_chain_reader.sv
// Directed bench for column_chain_reader: DUT A uses default parameters,
// DUT B uses SETTLE = 0 and a 3-bit counter.
module tb_column_chain_reader;

  logic clk;
  logic reset;
  logic [26:0] bcstIn;
  logic clearCount;

  logic        readEnableA, outReadyA, hitRightA, hitLeftA;
  logic [45:0] dataRightA, dataLeftA;
  logic        dnReadRightA, dnReadLeftA, outValidA, busyA;
  logic [26:0] bcstRightA, bcstLeftA;
  logic [46:0] outDataA;
  logic [11:0] wordCountRightA, wordCountLeftA;

  logic        readEnableB, outReadyB, hitRightB, hitLeftB;
  logic [45:0] dataRightB, dataLeftB;
  logic        dnReadRightB, dnReadLeftB, outValidB, busyB;
  logic [26:0] bcstRightB, bcstLeftB;
  logic [46:0] outDataB;
  logic [2:0]  wordCountRightB, wordCountLeftB;

  int nCompared = 0;
  int nMism = 0;
  bit gotR, gotL;
  int strobes;

  logic [45:0] D1, D2, D3;

  column_chain_reader dutA (
    .clk(clk), .reset(reset), .readEnable(readEnableA), .bcstIn(bcstIn),
    .clearCount(clearCount),
    .dnDataRight(dataRightA), .dnUnreadHitRight(hitRightA), .dnReadRight(dnReadRightA),
    .dnBCSTRight(bcstRightA),
    .dnDataLeft(dataLeftA), .dnUnreadHitLeft(hitLeftA), .dnReadLeft(dnReadLeftA),
    .dnBCSTLeft(bcstLeftA),
    .outData(outDataA), .outValid(outValidA), .outReady(outReadyA),
    .wordCountRight(wordCountRightA), .wordCountLeft(wordCountLeftA), .busy(busyA)
  );

  column_chain_reader #(.SETTLE(0), .CNTWIDTH(3)) dutB (
    .clk(clk), .reset(reset), .readEnable(readEnableB), .bcstIn(bcstIn),
    .clearCount(clearCount),
    .dnDataRight(dataRightB), .dnUnreadHitRight(hitRightB), .dnReadRight(dnReadRightB),
    .dnBCSTRight(bcstRightB),
    .dnDataLeft(dataLeftB), .dnUnreadHitLeft(hitLeftB), .dnReadLeft(dnReadLeftB),
    .dnBCSTLeft(bcstLeftB),
    .outData(outDataB), .outValid(outValidB), .outReady(outReadyB),
    .wordCountRight(wordCountRightB), .wordCountLeft(wordCountLeftB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until either strobe of the chosen DUT is seen, within a cycle budget.
  task automatic waitStrobe(input bit onB, input int budget, output bit r, output bit l);
    r = 1'b0;
    l = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      r = onB ? dnReadRightB : dnReadRightA;
      l = onB ? dnReadLeftB : dnReadLeftA;
      if (r || l) break;
    end
    check("strobe_seen", {63'd0, (r | l)}, 64'd1);
  endtask

  initial begin
    D1 = 46'h2A5A12345678;
    D2 = 46'h1F0F0F0F0F0F;
    D3 = 46'h3C3C3C3C3C3C;

    // Reset held with busy random inputs.
    reset = 1'b1;
    clearCount = 1'b0;
    bcstIn = 27'($urandom());
    readEnableA = 1'b1; outReadyA = 1'b1; hitRightA = 1'b1; hitLeftA = 1'b1;
    dataRightA = 46'({$urandom(), $urandom()}); dataLeftA = 46'({$urandom(), $urandom()});
    readEnableB = 1'b1; outReadyB = 1'b0; hitRightB = 1'b1; hitLeftB = 1'b1;
    dataRightB = 46'({$urandom(), $urandom()}); dataLeftB = 46'({$urandom(), $urandom()});
    tick(); tick(); tick();
    check("rst_dnReadRight", {63'd0, dnReadRightA}, 64'd0);
    check("rst_dnReadLeft", {63'd0, dnReadLeftA}, 64'd0);
    check("rst_bcstRight", {37'd0, bcstRightA}, 64'd0);
    check("rst_bcstLeft", {37'd0, bcstLeftA}, 64'd0);
    check("rst_outData", {17'd0, outDataA}, 64'd0);
    check("rst_outValid", {63'd0, outValidA}, 64'd0);
    check("rst_countR", {52'd0, wordCountRightA}, 64'd0);
    check("rst_countL", {52'd0, wordCountLeftA}, 64'd0);
    check("rst_busy", {63'd0, busyA}, 64'd0);
    check("rst_busyB", {63'd0, busyB}, 64'd0);

    // Release with no hits: nothing moves.
    bcstIn = 27'd0;
    readEnableA = 1'b0; outReadyA = 1'b0; hitRightA = 1'b0; hitLeftA = 1'b0;
    readEnableB = 1'b0; outReadyB = 1'b0; hitRightB = 1'b0; hitLeftB = 1'b0;
    reset = 1'b0;
    tick(); tick(); tick();
    check("idle_busy", {63'd0, busyA}, 64'd0);
    check("idle_outValid", {63'd0, outValidA}, 64'd0);
    check("idle_dnReadRight", {63'd0, dnReadRightA}, 64'd0);
    check("idle_countR", {52'd0, wordCountRightA}, 64'd0);

    // Broadcast register has one cycle of latency.
    bcstIn = 27'h5A5A5A5;
    check("bcst_before_edge", {37'd0, bcstRightA}, 64'd0);
    tick();
    check("bcst_right", {37'd0, bcstRightA}, 64'h5A5A5A5);
    check("bcst_left", {37'd0, bcstLeftA}, 64'h5A5A5A5);
    check("bcst_rightB", {37'd0, bcstRightB}, 64'h5A5A5A5);

    // Single right hit with SETTLE = 2.
    readEnableA = 1'b1; dataRightA = D1; hitRightA = 1'b1;
    tick();
    check("single_strobeR", {63'd0, dnReadRightA}, 64'd1);
    check("single_strobeL", {63'd0, dnReadLeftA}, 64'd0);
    check("single_outValid", {63'd0, outValidA}, 64'd1);
    check("single_outData", {17'd0, outDataA}, {18'd0, D1});
    check("single_countR", {52'd0, wordCountRightA}, 64'd1);
    check("single_busy", {63'd0, busyA}, 64'd1);
    dataRightA = D2;
    tick();
    check("settle_strobe_1", {63'd0, dnReadRightA}, 64'd0);
    tick();
    check("settle_strobe_2", {63'd0, dnReadRightA}, 64'd0);
    tick();
    check("settle_strobe_3", {63'd0, dnReadRightA}, 64'd0);
    check("settle_idle_busy", {63'd0, busyA}, 64'd0);
    tick();
    check("second_strobeR", {63'd0, dnReadRightA}, 64'd1);
    check("second_countR", {52'd0, wordCountRightA}, 64'd2);
    check("second_head_still_first", {17'd0, outDataA}, {18'd0, D1});
    hitRightA = 1'b0;
    outReadyA = 1'b1;
    tick();
    check("pop_head_second", {17'd0, outDataA}, {18'd0, D2});
    tick();
    check("pop_empty", {63'd0, outValidA}, 64'd0);
    outReadyA = 1'b0;
    tick(); tick();

    // Round robin from reset: R, L, R, L, R, L.
    reset = 1'b1; tick(); reset = 1'b0;
    dataRightA = D1; dataLeftA = D3; outReadyA = 1'b1;
    hitRightA = 1'b1; hitLeftA = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waitStrobe(1'b0, 12, gotR, gotL);
      check("rr_side", {62'd0, gotL, gotR}, (i % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_outData", {17'd0, outDataA},
            (i % 2 == 0) ? {18'd0, 1'b0, D1} : {18'd0, 1'b1, D3});
    end
    hitRightA = 1'b0; hitLeftA = 1'b0;
    tick(); tick(); tick(); tick();
    check("rr_countR", {52'd0, wordCountRightA}, 64'd3);
    check("rr_countL", {52'd0, wordCountLeftA}, 64'd3);

    // Backpressure: FIFO of 4 fills, then one pop allows exactly one more read.
    reset = 1'b1; tick(); reset = 1'b0;
    outReadyA = 1'b0; hitRightA = 1'b1;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dnReadRightA) strobes++;
    end
    check("bp_strobes", 64'(strobes), 64'd4);
    check("bp_busy", {63'd0, busyA}, 64'd0);
    check("bp_outValid", {63'd0, outValidA}, 64'd1);
    check("bp_countR", {52'd0, wordCountRightA}, 64'd4);
    outReadyA = 1'b1;
    tick();
    outReadyA = 1'b0;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dnReadRightA) strobes++;
    end
    check("bp_one_more", 64'(strobes), 64'd1);
    check("bp_countR_after", {52'd0, wordCountRightA}, 64'd5);

    // Asynchronous reset in a READ cycle.
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    check("midread_strobe", {63'd0, dnReadRightA}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midread_strobe_dropped", {63'd0, dnReadRightA}, 64'd0);
    check("midread_fifo_empty", {63'd0, outValidA}, 64'd0);
    check("midread_busy", {63'd0, busyA}, 64'd0);
    hitRightA = 1'b0; readEnableA = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // SETTLE = 0: continuous left hit strobes every 2 cycles.
    readEnableB = 1'b1; outReadyB = 1'b1; dataLeftB = D3; hitLeftB = 1'b1;
    waitStrobe(1'b1, 6, gotR, gotL);
    check("s0_first_left", {63'd0, gotL}, 64'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("s0_pulse", {63'd0, dnReadLeftB}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    hitLeftB = 1'b0;
    tick(); tick();
    clearCount = 1'b1;
    tick();
    clearCount = 1'b0;
    check("clear_countL", {61'd0, wordCountLeftB}, 64'd0);

    // 3-bit counter saturates after 9 right reads.
    dataRightB = D2; hitRightB = 1'b1;
    for (int n = 0; n < 9; n++) begin
      waitStrobe(1'b1, 6, gotR, gotL);
    end
    hitRightB = 1'b0;
    tick(); tick();
    check("sat_countR", {61'd0, wordCountRightB}, 64'd7);

    // Clear coincident with an increment leaves the counter at zero.
    hitRightB = 1'b1;
    waitStrobe(1'b1, 6, gotR, gotL);
    tick();
    clearCount = 1'b1;
    tick();
    check("clr_coinc_strobe", {63'd0, dnReadRightB}, 64'd1);
    check("clr_coinc_count", {61'd0, wordCountRightB}, 64'd0);
    clearCount = 1'b0;
    hitRightB = 1'b0;
    tick(); tick();
    check("clr_coinc_after", {61'd0, wordCountRightB}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMism);
    $finish;
  end

endmodule
